axi_demux: RTL and testbench
============================

Name: axi_demux

Overview:
- 1-to-N AXI splitter: one upstream AXI master port fans out to OUTPUT_NUM downstream slave ports.
- AW/AR are routed by address-range decode; W follows the AW order; B/R are returned from the active destination.
- Allows only one destination per direction while transactions are outstanding, so responses stay ordered without ID remapping.
- Sits between a master (or a NoC router output) and the per-slave axi_mux stages.

Parameters:
- OUTPUT_NUM, 3, number of downstream ports (>=2).
- ADDR_ROUTING, '{16'h0000,16'h3FFF,16'h4000,16'h7FFF}, (OUTPUT_NUM-1) inclusive {low,high} pairs; port j owns [ADDR_ROUTING[2j], ADDR_ROUTING[2j+1]]; unmatched addresses go to port OUTPUT_NUM-1.
- AXI_DATA_WIDTH, 32, data width.
- ID_W_WIDTH, 4, write ID width.
- ID_R_WIDTH, 4, read ID width.
- ADDR_WIDTH, 16, address width.
- W_FIFO_LEN, 4, depth of the W-route FIFO (power of 2).
- MAX_OUTSTANDING, 8, max outstanding writes and max outstanding reads, counted separately.

Ports:
- ACLK  input  1  clock; all logic on the rising edge.
- ARESETn  input  1  asynchronous, active-low reset.
- s_axi_i  input  axi_mosi_t  upstream master requests.
- s_axi_o  output  axi_miso_t  upstream responses.
- m_axi_o  output  axi_mosi_t[OUTPUT_NUM]  downstream requests.
- m_axi_i  input  axi_miso_t[OUTPUT_NUM]  downstream responses.

Behaviour:
- Decode:
  - port(addr) = lowest j in 0..OUTPUT_NUM-2 with low_j <= addr <= high_j, else OUTPUT_NUM-1.
  - Combinational, applied to AWADDR and ARADDR.
- Write state registers:
  - wr_cnt: 0..MAX_OUTSTANDING, width $clog2(MAX_OUTSTANDING+1).
  - wr_port: port of outstanding writes.
  - W-route FIFO of port indices: wptr/rptr plus extra wrap bit.
  - Full when pointers are equal except the MSB; empty when fully equal.
- AW accept condition aw_ok:
  - W FIFO not full,
  - wr_cnt < MAX_OUTSTANDING,
  - (wr_cnt == 0 or wr_port == port(AWADDR)).
- AW routing:
  - m_axi_o[p].AWVALID = s AWVALID & aw_ok; all other ports' AWVALID = 0.
  - AW payload is broadcast to all ports.
  - s AWREADY = m_axi_i[p].AWREADY & aw_ok.
- AW handshake:
  - Push p into the W FIFO, wr_cnt++, wr_port <= p.
  - Held AWVALID with changing readiness is legal; no AWVALID deassert toward the slave once asserted unless upstream deasserts (upstream must hold per AXI).
- W routing:
  - FIFO non-empty: head h; m_axi_o[h].WVALID = s WVALID; s WREADY = m_axi_i[h].WREADY; other ports' WVALID = 0.
  - FIFO empty: s WREADY = 0, all WVALID = 0.
  - No bypass: the first W beat can leave at earliest the cycle after the AW handshake.
- Pop the W FIFO on a W handshake with WLAST = 1. Simultaneous push and pop are both honoured; the FIFO count is unchanged.
- B channel:
  - s BVALID/BID come from m_axi_i[wr_port]; m_axi_o[wr_port].BREADY = s BREADY.
  - Every other port's BREADY = 0.
  - When wr_cnt == 0: s BVALID = 0 and all BREADY = 0.
  - B handshake: wr_cnt--. AW handshake and B handshake in the same cycle: wr_cnt unchanged.
- Read path: identical scheme with rd_cnt and rd_port, no FIFO.
  - ar_ok = rd_cnt < MAX_OUTSTANDING and (rd_cnt == 0 or rd_port == port(ARADDR)).
  - R is forwarded from rd_port; other ports' RREADY = 0.
  - rd_cnt-- only on an R handshake with RLAST = 1.
  - Simultaneous AR handshake and last-R handshake: rd_cnt unchanged.
- Blocking: an AW or AR to a different port waits (READY = 0) until the respective counter drains to 0, then switches in the same cycle the count is observed as 0.
- Reset (async assert, sync-safe deassert):
  - wr_cnt = rd_cnt = 0; wr_port = rd_port = 0; FIFO pointers = 0.
  - Consequently all m_axi_o VALIDs = 0 and s BVALID = RVALID = 0.
  - s AWREADY/ARREADY/WREADY = 0 while reset is asserted.
  - Unused output payload fields = 0.
  - Reset mid-burst drops all tracking; no recovery of in-flight transactions.

Test Plan:
- Reset then single write: AWADDR=16'h4010, LEN=3 -> only port 1 sees AWVALID; 4 W beats on port 1 only; WREADY low in the AW cycle; BVALID upstream; wr_cnt returns to 0.
- Unmatched address: ARADDR=16'hC000, LEN=0 -> AR on port 2; R returned upstream with RLAST; rd_cnt 1 -> 0.
- Port switch stall: AW to 16'h0100, then AW to 16'h5000 before B -> second AWREADY = 0 until the first B handshake; second AW accepted in the cycle wr_cnt reads 0.
- W FIFO full: issue 4 AWs to port 0 with WVALID = 0 -> 5th AWREADY = 0; send one WLAST beat -> 5th accepted next cycle.
- Simultaneous events: last-R handshake and AR to the same port in one cycle -> rd_cnt unchanged; B and AW handshakes together -> wr_cnt unchanged.
- Reset mid-burst: assert ARESETn = 0 after 2 of 4 W beats -> all downstream VALIDs 0 immediately; counters and FIFO are 0 after release.

Source files
------------

// File: rtl/axi_demux_pkg.sv
// AXI bus payload types shared by the demux and its neighbours.
// One mosi/miso struct pair carries all five channels of a port.
package axi_demux_pkg;

   localparam int unsigned AXI_DATA_WIDTH = 32;
   localparam int unsigned ID_W_WIDTH     = 4;
   localparam int unsigned ID_R_WIDTH     = 4;
   localparam int unsigned ADDR_WIDTH     = 16;
   localparam int unsigned STRB_WIDTH     = AXI_DATA_WIDTH / 8;

   typedef struct packed {
      logic [ID_W_WIDTH-1:0]     awid;
      logic [ADDR_WIDTH-1:0]     awaddr;
      logic [7:0]                awlen;
      logic [2:0]                awsize;
      logic [1:0]                awburst;
      logic                      awvalid;
      logic [AXI_DATA_WIDTH-1:0] wdata;
      logic [STRB_WIDTH-1:0]     wstrb;
      logic                      wlast;
      logic                      wvalid;
      logic                      bready;
      logic [ID_R_WIDTH-1:0]     arid;
      logic [ADDR_WIDTH-1:0]     araddr;
      logic [7:0]                arlen;
      logic [2:0]                arsize;
      logic [1:0]                arburst;
      logic                      arvalid;
      logic                      rready;
   } axi_mosi_t;

   typedef struct packed {
      logic                      awready;
      logic                      wready;
      logic [ID_W_WIDTH-1:0]     bid;
      logic [1:0]                bresp;
      logic                      bvalid;
      logic                      arready;
      logic [ID_R_WIDTH-1:0]     rid;
      logic [AXI_DATA_WIDTH-1:0] rdata;
      logic [1:0]                rresp;
      logic                      rlast;
      logic                      rvalid;
   } axi_miso_t;

endpackage

// File: rtl/axi_demux.sv
// 1-to-N AXI splitter: address-decoded AW/AR, W steered by an AW-order FIFO,
// one active destination per direction so B/R stay ordered without ID remap.
module axi_demux #(
   parameter int unsigned OUTPUT_NUM      = 3,
   parameter int unsigned AXI_DATA_WIDTH  = axi_demux_pkg::AXI_DATA_WIDTH,
   parameter int unsigned ID_W_WIDTH      = axi_demux_pkg::ID_W_WIDTH,
   parameter int unsigned ID_R_WIDTH      = axi_demux_pkg::ID_R_WIDTH,
   parameter int unsigned ADDR_WIDTH      = axi_demux_pkg::ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] ADDR_ROUTING [2*(OUTPUT_NUM-1)] =
      '{16'h0000, 16'h3FFF, 16'h4000, 16'h7FFF},
   parameter int unsigned W_FIFO_LEN      = 4,
   parameter int unsigned MAX_OUTSTANDING = 8
) (
   input  logic                     ACLK,
   input  logic                     ARESETn,
   input  axi_demux_pkg::axi_mosi_t s_axi_i,
   output axi_demux_pkg::axi_miso_t s_axi_o,
   output axi_demux_pkg::axi_mosi_t m_axi_o [OUTPUT_NUM],
   input  axi_demux_pkg::axi_miso_t m_axi_i [OUTPUT_NUM]
);

   localparam int unsigned PORT_W  = $clog2(OUTPUT_NUM);
   localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned PTR_W   = $clog2(W_FIFO_LEN);
   localparam int unsigned FIFO_AW = PTR_W + 1;

   logic [CNT_W-1:0]   wr_cnt, rd_cnt;
   logic [PORT_W-1:0]  wr_port, rd_port;
   logic [FIFO_AW-1:0] wptr, rptr;
   logic [PORT_W-1:0]  fifo_mem [W_FIFO_LEN];
   logic [PORT_W-1:0]  aw_port, ar_port, w_head;
   logic               fifo_full, fifo_empty, wr_busy, rd_busy;
   logic               aw_ok, ar_ok;
   logic               aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;

   // Lowest matching range wins; anything unmatched goes to the last port.
   function automatic logic [PORT_W-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
      decode = PORT_W'(OUTPUT_NUM - 1);
      for (int j = int'(OUTPUT_NUM) - 2; j >= 0; j--) begin
         if (addr >= ADDR_ROUTING[2*j] && addr <= ADDR_ROUTING[2*j+1])
            decode = PORT_W'(j);
      end
   endfunction

   assign aw_port    = decode(s_axi_i.awaddr);
   assign ar_port    = decode(s_axi_i.araddr);
   assign fifo_empty = (wptr == rptr);
   assign fifo_full  = (wptr == {~rptr[PTR_W], rptr[PTR_W-1:0]});
   assign w_head     = fifo_mem[rptr[PTR_W-1:0]];
   assign wr_busy    = (wr_cnt != '0);
   assign rd_busy    = (rd_cnt != '0);

   // Reset gates acceptance so nothing leaks downstream while ARESETn is low.
   assign aw_ok = ARESETn && !fifo_full && (wr_cnt < CNT_W'(MAX_OUTSTANDING)) &&
                  (!wr_busy || wr_port == aw_port);
   assign ar_ok = ARESETn && (rd_cnt < CNT_W'(MAX_OUTSTANDING)) &&
                  (!rd_busy || rd_port == ar_port);

   assign aw_hs     = s_axi_i.awvalid && aw_ok && m_axi_i[aw_port].awready;
   assign w_last_hs = !fifo_empty && s_axi_i.wvalid && s_axi_i.wlast && m_axi_i[w_head].wready;
   assign b_hs      = wr_busy && m_axi_i[wr_port].bvalid && s_axi_i.bready;
   assign ar_hs     = s_axi_i.arvalid && ar_ok && m_axi_i[ar_port].arready;
   assign r_last_hs = rd_busy && m_axi_i[rd_port].rvalid && s_axi_i.rready &&
                      m_axi_i[rd_port].rlast;

   // Outstanding tracking and W-route pointers.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_cnt  <= '0;
         rd_cnt  <= '0;
         wr_port <= '0;
         rd_port <= '0;
         wptr    <= '0;
         rptr    <= '0;
      end else begin
         wr_cnt <= wr_cnt + CNT_W'(aw_hs) - CNT_W'(b_hs);
         rd_cnt <= rd_cnt + CNT_W'(ar_hs) - CNT_W'(r_last_hs);
         if (aw_hs) begin
            wr_port <= aw_port;
            wptr    <= wptr + FIFO_AW'(1);
         end
         if (ar_hs)
            rd_port <= ar_port;
         if (w_last_hs)
            rptr <= rptr + FIFO_AW'(1);
      end
   end

   always_ff @(posedge ACLK) begin
      if (aw_hs)
         fifo_mem[wptr[PTR_W-1:0]] <= aw_port;
   end

   // Upstream responses come from the active destination of each direction.
   always_comb begin
      s_axi_o         = '0;
      s_axi_o.awready = aw_ok && m_axi_i[aw_port].awready;
      s_axi_o.wready  = !fifo_empty && m_axi_i[w_head].wready;
      s_axi_o.bvalid  = wr_busy && m_axi_i[wr_port].bvalid;
      s_axi_o.bid     = ID_W_WIDTH'(m_axi_i[wr_port].bid);
      s_axi_o.bresp   = m_axi_i[wr_port].bresp;
      s_axi_o.arready = ar_ok && m_axi_i[ar_port].arready;
      s_axi_o.rvalid  = rd_busy && m_axi_i[rd_port].rvalid;
      s_axi_o.rid     = ID_R_WIDTH'(m_axi_i[rd_port].rid);
      s_axi_o.rdata   = AXI_DATA_WIDTH'(m_axi_i[rd_port].rdata);
      s_axi_o.rresp   = m_axi_i[rd_port].rresp;
      s_axi_o.rlast   = m_axi_i[rd_port].rlast;
   end

   // Payload is broadcast; only the selected port sees VALID/READY.
   always_comb begin
      for (int i = 0; i < int'(OUTPUT_NUM); i++) begin
         m_axi_o[i]         = '0;
         m_axi_o[i].awid    = ID_W_WIDTH'(s_axi_i.awid);
         m_axi_o[i].awaddr  = ADDR_WIDTH'(s_axi_i.awaddr);
         m_axi_o[i].awlen   = s_axi_i.awlen;
         m_axi_o[i].awsize  = s_axi_i.awsize;
         m_axi_o[i].awburst = s_axi_i.awburst;
         m_axi_o[i].awvalid = s_axi_i.awvalid && aw_ok && (aw_port == PORT_W'(i));
         m_axi_o[i].wdata   = AXI_DATA_WIDTH'(s_axi_i.wdata);
         m_axi_o[i].wstrb   = s_axi_i.wstrb;
         m_axi_o[i].wlast   = s_axi_i.wlast;
         m_axi_o[i].wvalid  = !fifo_empty && s_axi_i.wvalid && (w_head == PORT_W'(i));
         m_axi_o[i].bready  = wr_busy && s_axi_i.bready && (wr_port == PORT_W'(i));
         m_axi_o[i].arid    = ID_R_WIDTH'(s_axi_i.arid);
         m_axi_o[i].araddr  = ADDR_WIDTH'(s_axi_i.araddr);
         m_axi_o[i].arlen   = s_axi_i.arlen;
         m_axi_o[i].arsize  = s_axi_i.arsize;
         m_axi_o[i].arburst = s_axi_i.arburst;
         m_axi_o[i].arvalid = s_axi_i.arvalid && ar_ok && (ar_port == PORT_W'(i));
         m_axi_o[i].rready  = rd_busy && s_axi_i.rready && (rd_port == PORT_W'(i));
      end
   end

endmodule

// File: tb/tb_axi_demux.sv
// Bench for axi_demux: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model built from queues and counters.
module tb_axi_demux;
   import axi_demux_pkg::*;

   localparam int N        = 3;
   localparam int MAX_OUT  = 8;
   localparam int FIFO_LEN = 4;
   localparam int SEL_AW = 0, SEL_W = 1, SEL_B = 2, SEL_AR = 3, SEL_R = 4;

   logic      ACLK = 1'b0;
   logic      ARESETn;
   axi_mosi_t s_in;
   axi_miso_t s_out;
   axi_mosi_t m_out [N];
   axi_miso_t m_in  [N];

   int unsigned errors = 0;
   int unsigned checks = 0;

   // Model state: outstanding counts, active ports, and pending W routes.
   int wr_cnt_m, wr_port_m, rd_cnt_m, rd_port_m;
   int wq[$];
   int e_ap, e_rp;
   bit e_aw_hs, e_w_hs, e_wpop, e_b_hs, e_ar_hs, e_rlast;

   axi_demux #(
      .OUTPUT_NUM(N), .AXI_DATA_WIDTH(32), .ID_W_WIDTH(4), .ID_R_WIDTH(4),
      .ADDR_WIDTH(16), .ADDR_ROUTING('{16'h0000, 16'h3FFF, 16'h4000, 16'h7FFF}),
      .W_FIFO_LEN(FIFO_LEN), .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .s_axi_i(s_in), .s_axi_o(s_out),
      .m_axi_o(m_out), .m_axi_i(m_in)
   );

   always #5 ACLK = ~ACLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_port(input logic [15:0] a);
      if (a <= 16'h3FFF) return 0;
      if (a >= 16'h4000 && a <= 16'h7FFF) return 1;
      return 2;
   endfunction

   function automatic logic [N-1:0] dut_vec(input int sel);
      logic [N-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) begin
         case (sel)
            SEL_AW:  v[i] = m_out[i].awvalid;
            SEL_W:   v[i] = m_out[i].wvalid;
            SEL_B:   v[i] = m_out[i].bready;
            SEL_AR:  v[i] = m_out[i].arvalid;
            default: v[i] = m_out[i].rready;
         endcase
      end
      return v;
   endfunction

   task automatic reset_model();
      wr_cnt_m = 0; wr_port_m = 0; rd_cnt_m = 0; rd_port_m = 0;
      wq.delete();
   endtask

   // Compare every DUT output against the model, then record handshakes.
   task automatic evaluate();
      logic [N-1:0] awv, wv, brd, arv, rrd;
      bit aw_ok, ar_ok, w_open, wr_busy, rd_busy, live;
      bit x_awready, x_wready, x_arready;
      int head, k;
      live    = (ARESETn === 1'b1);
      e_ap    = ref_port(s_in.awaddr);
      e_rp    = ref_port(s_in.araddr);
      w_open  = (wq.size() != 0);
      head    = w_open ? wq[0] : 0;
      wr_busy = (wr_cnt_m != 0);
      rd_busy = (rd_cnt_m != 0);
      aw_ok = live && (wq.size() < FIFO_LEN) && (wr_cnt_m < MAX_OUT) &&
              (!wr_busy || wr_port_m == e_ap);
      ar_ok = live && (rd_cnt_m < MAX_OUT) && (!rd_busy || rd_port_m == e_rp);
      for (int i = 0; i < N; i++) begin
         awv[i] = s_in.awvalid && aw_ok && (i == e_ap);
         wv[i]  = w_open && s_in.wvalid && (i == head);
         brd[i] = wr_busy && s_in.bready && (i == wr_port_m);
         arv[i] = s_in.arvalid && ar_ok && (i == e_rp);
         rrd[i] = rd_busy && s_in.rready && (i == rd_port_m);
      end
      x_awready = aw_ok && m_in[e_ap].awready;
      x_wready  = w_open && m_in[head].wready;
      x_arready = ar_ok && m_in[e_rp].arready;
      check("m_awvalid", 64'(dut_vec(SEL_AW)), 64'(awv));
      check("m_wvalid",  64'(dut_vec(SEL_W)),  64'(wv));
      check("m_bready",  64'(dut_vec(SEL_B)),  64'(brd));
      check("m_arvalid", 64'(dut_vec(SEL_AR)), 64'(arv));
      check("m_rready",  64'(dut_vec(SEL_R)),  64'(rrd));
      check("s_awready", 64'(s_out.awready), 64'(x_awready));
      check("s_wready",  64'(s_out.wready),  64'(x_wready));
      check("s_arready", 64'(s_out.arready), 64'(x_arready));
      check("s_bvalid",  64'(s_out.bvalid),  64'(wr_busy && m_in[wr_port_m].bvalid));
      check("s_rvalid",  64'(s_out.rvalid),  64'(rd_busy && m_in[rd_port_m].rvalid));
      if (wr_busy)
         check("s_bid", 64'(s_out.bid), 64'(m_in[wr_port_m].bid));
      if (rd_busy) begin
         check("s_rdata", 64'(s_out.rdata), 64'(m_in[rd_port_m].rdata));
         check("s_rlast", 64'(s_out.rlast), 64'(m_in[rd_port_m].rlast));
      end
      if (live) begin
         k = int'($urandom_range(N - 1));
         check("m_awaddr", 64'(m_out[k].awaddr), 64'(s_in.awaddr));
         check("m_araddr", 64'(m_out[k].araddr), 64'(s_in.araddr));
         check("m_wdata",  64'(m_out[k].wdata),  64'(s_in.wdata));
      end
      e_aw_hs = s_in.awvalid && x_awready;
      e_w_hs  = s_in.wvalid && x_wready;
      e_wpop  = e_w_hs && s_in.wlast;
      e_b_hs  = wr_busy && m_in[wr_port_m].bvalid && s_in.bready;
      e_ar_hs = s_in.arvalid && x_arready;
      e_rlast = rd_busy && m_in[rd_port_m].rvalid && s_in.rready && m_in[rd_port_m].rlast;
   endtask

   task automatic update_model();
      if (e_aw_hs) begin wq.push_back(e_ap); wr_cnt_m++; wr_port_m = e_ap; end
      if (e_wpop) void'(wq.pop_front());
      if (e_b_hs) wr_cnt_m--;
      if (e_ar_hs) begin rd_cnt_m++; rd_port_m = e_rp; end
      if (e_rlast) rd_cnt_m--;
   endtask

   // One clock: check at negedge+1, advance the model at the rising edge.
   task automatic cycle();
      #1 evaluate();
      @(posedge ACLK);
      if (ARESETn === 1'b1) update_model(); else reset_model();
      @(negedge ACLK);
   endtask

   task automatic idle();
      s_in = '0;
      s_in.bready = 1'b1;
      s_in.rready = 1'b1;
      for (int i = 0; i < N; i++) begin
         m_in[i] = '0;
         m_in[i].awready = 1'b1;
         m_in[i].wready  = 1'b1;
         m_in[i].arready = 1'b1;
      end
   endtask

   function automatic logic [15:0] rand_addr();
      case ($urandom_range(6))
         0: return 16'h0100;
         1: return 16'h3FFF;
         2: return 16'h4000;
         3: return 16'h7FFF;
         4: return 16'h8000;
         5: return 16'hC000;
         default: return 16'($urandom);
      endcase
   endfunction

   // Upstream holds VALID and payload until the handshake, per AXI.
   task automatic drive_random();
      if (!(s_in.awvalid && !e_aw_hs)) begin
         s_in.awvalid = ($urandom_range(99) < 40);
         s_in.awaddr  = rand_addr();
         s_in.awid    = 4'($urandom);
         s_in.awlen   = 8'($urandom_range(3));
      end
      if (!(s_in.wvalid && !e_w_hs)) begin
         s_in.wvalid = ($urandom_range(99) < 50);
         s_in.wlast  = ($urandom_range(99) < 40);
         s_in.wdata  = 32'($urandom);
         s_in.wstrb  = 4'($urandom);
      end
      if (!(s_in.arvalid && !e_ar_hs)) begin
         s_in.arvalid = ($urandom_range(99) < 40);
         s_in.araddr  = rand_addr();
         s_in.arid    = 4'($urandom);
      end
      s_in.bready = ($urandom_range(99) < 80);
      s_in.rready = ($urandom_range(99) < 80);
      for (int i = 0; i < N; i++) begin
         m_in[i].awready = ($urandom_range(99) < 75);
         m_in[i].wready  = ($urandom_range(99) < 75);
         m_in[i].arready = ($urandom_range(99) < 75);
         m_in[i].bvalid  = ($urandom_range(99) < 40);
         m_in[i].bid     = 4'($urandom);
         m_in[i].rvalid  = ($urandom_range(99) < 40);
         m_in[i].rlast   = ($urandom_range(99) < 50);
         m_in[i].rid     = 4'($urandom);
         m_in[i].rdata   = 32'($urandom);
      end
   endtask

   initial begin
      ARESETn = 1'b0;
      idle();
      reset_model();
      s_in.awvalid = 1'b1; s_in.arvalid = 1'b1; s_in.wvalid = 1'b1;
      m_in[0].bvalid = 1'b1; m_in[0].rvalid = 1'b1;
      @(negedge ACLK);
      #1;
      check("rst_awvalid", 64'(dut_vec(SEL_AW)), 64'(0));
      check("rst_awready", 64'(s_out.awready), 64'(0));
      check("rst_arready", 64'(s_out.arready), 64'(0));
      check("rst_wready",  64'(s_out.wready),  64'(0));
      check("rst_bvalid",  64'(s_out.bvalid),  64'(0));
      cycle();
      ARESETn = 1'b1;
      idle();

      // Single write to port 1, four beats.
      s_in.awvalid = 1'b1; s_in.awaddr = 16'h4010; s_in.awlen = 8'd3; s_in.awid = 4'h5;
      s_in.wvalid = 1'b1;
      #1;
      check("t1_awvalid", 64'(dut_vec(SEL_AW)), 64'(3'b010));
      check("t1_wready_aw_cycle", 64'(s_out.wready), 64'(0));
      cycle();
      s_in.awvalid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         s_in.wlast = (b == 3);
         s_in.wdata = 32'($urandom);
         #1;
         check("t1_wvalid", 64'(dut_vec(SEL_W)), 64'(3'b010));
         cycle();
      end
      s_in.wvalid = 1'b0; s_in.wlast = 1'b0;
      m_in[1].bvalid = 1'b1; m_in[1].bid = 4'h5;
      #1;
      check("t1_bvalid", 64'(s_out.bvalid), 64'(1));
      check("t1_bid",    64'(s_out.bid),    64'(5));
      cycle();
      #1 check("t1_bvalid_drained", 64'(s_out.bvalid), 64'(0));
      m_in[1].bvalid = 1'b0;
      cycle();

      // Unmatched read address lands on port 2.
      s_in.arvalid = 1'b1; s_in.araddr = 16'hC000; s_in.arlen = 8'd0; s_in.arid = 4'h3;
      #1 check("t2_arvalid", 64'(dut_vec(SEL_AR)), 64'(3'b100));
      cycle();
      s_in.arvalid = 1'b0;
      m_in[2].rvalid = 1'b1; m_in[2].rlast = 1'b1; m_in[2].rdata = 32'hCAFE0001; m_in[2].rid = 4'h3;
      #1;
      check("t2_rvalid", 64'(s_out.rvalid), 64'(1));
      check("t2_rdata",  64'(s_out.rdata),  64'(32'hCAFE0001));
      cycle();
      #1 check("t2_rvalid_drained", 64'(s_out.rvalid), 64'(0));
      m_in[2] = '0; m_in[2].awready = 1'b1; m_in[2].wready = 1'b1; m_in[2].arready = 1'b1;
      cycle();

      // Port switch stalls until the first write's B drains the count.
      s_in.awvalid = 1'b1; s_in.awaddr = 16'h0100;
      cycle();
      s_in.awaddr = 16'h5000;
      #1 check("t3_stall", 64'(s_out.awready), 64'(0));
      cycle();
      m_in[0].bvalid = 1'b1;
      #1 check("t3_stall_during_b", 64'(s_out.awready), 64'(0));
      cycle();
      m_in[0].bvalid = 1'b0;
      #1;
      check("t3_switch", 64'(s_out.awready), 64'(1));
      check("t3_awvalid", 64'(dut_vec(SEL_AW)), 64'(3'b010));
      cycle();
      s_in.awvalid = 1'b0;
      s_in.wvalid = 1'b1; s_in.wlast = 1'b1;
      #1 check("t3_w_first", 64'(dut_vec(SEL_W)), 64'(3'b001));
      cycle();
      #1 check("t3_w_second", 64'(dut_vec(SEL_W)), 64'(3'b010));
      cycle();
      s_in.wvalid = 1'b0;
      m_in[1].bvalid = 1'b1;
      cycle();
      m_in[1].bvalid = 1'b0;
      cycle();

      // W route FIFO fills after four AWs with no W traffic.
      s_in.awvalid = 1'b1; s_in.awaddr = 16'h0100; s_in.wlast = 1'b1;
      repeat (4) cycle();
      #1 check("t4_full", 64'(s_out.awready), 64'(0));
      cycle();
      s_in.wvalid = 1'b1;
      #1 check("t4_full_during_pop", 64'(s_out.awready), 64'(0));
      cycle();
      s_in.wvalid = 1'b0;
      #1 check("t4_after_pop", 64'(s_out.awready), 64'(1));
      cycle();
      s_in.awvalid = 1'b0; s_in.wvalid = 1'b1;
      repeat (4) cycle();
      s_in.wvalid = 1'b0; m_in[0].bvalid = 1'b1;
      repeat (5) cycle();
      #1 check("t4_drained", 64'(s_out.bvalid), 64'(0));
      m_in[0].bvalid = 1'b0;
      cycle();

      // Same-cycle AR + last R, then AW + B, leave the counts unchanged.
      s_in.arvalid = 1'b1; s_in.araddr = 16'h0100;
      cycle();
      s_in.araddr = 16'h0200; m_in[0].rvalid = 1'b1; m_in[0].rlast = 1'b1;
      cycle();
      s_in.arvalid = 1'b0;
      #1 check("t5_rd_still_open", 64'(s_out.rvalid), 64'(1));
      cycle();
      #1 check("t5_rd_drained", 64'(s_out.rvalid), 64'(0));
      m_in[0].rvalid = 1'b0; m_in[0].rlast = 1'b0;
      s_in.awvalid = 1'b1; s_in.awaddr = 16'h0100;
      cycle();
      s_in.awvalid = 1'b0; s_in.wvalid = 1'b1; s_in.wlast = 1'b1;
      cycle();
      s_in.wvalid = 1'b0;
      s_in.awvalid = 1'b1; s_in.awaddr = 16'h0300; m_in[0].bvalid = 1'b1;
      cycle();
      s_in.awvalid = 1'b0;
      #1 check("t5_wr_still_open", 64'(s_out.bvalid), 64'(1));
      cycle();
      #1 check("t5_wr_drained", 64'(s_out.bvalid), 64'(0));
      m_in[0].bvalid = 1'b0; s_in.wvalid = 1'b1;
      cycle();
      s_in.wvalid = 1'b0;

      // Reset in the middle of a burst.
      s_in.awvalid = 1'b1; s_in.awaddr = 16'h4010; s_in.awlen = 8'd3;
      cycle();
      s_in.awvalid = 1'b0; s_in.wvalid = 1'b1; s_in.wlast = 1'b0;
      repeat (2) cycle();
      s_in.awvalid = 1'b1; s_in.arvalid = 1'b1; s_in.araddr = 16'h4000;
      #2 ARESETn = 1'b0;
      #1;
      check("t6_awvalid", 64'(dut_vec(SEL_AW)), 64'(0));
      check("t6_wvalid",  64'(dut_vec(SEL_W)),  64'(0));
      check("t6_arvalid", 64'(dut_vec(SEL_AR)), 64'(0));
      reset_model();
      cycle();
      ARESETn = 1'b1;
      s_in.awvalid = 1'b0; s_in.arvalid = 1'b0; m_in[1].bvalid = 1'b1;
      #1;
      check("t6_wready_post", 64'(s_out.wready), 64'(0));
      check("t6_bvalid_post", 64'(s_out.bvalid), 64'(0));
      cycle();
      idle();
      cycle();

      repeat (1500) begin
         drive_random();
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
